// File: rtl/camera_config_pkg.sv
// Shared types and constants for the camera configuration sequencer.
//   - cfg_op_t      : table entry opcode (WRITE, DELAY, END; code 3 behaves as END)
//   - cfg_state_t   : sequencer FSM states
//   - cfg_entry_t   : entry layout for the default 8-bit register/value widths
//   - cfg_entry()   : packs {op, reg, val} into one table word
//   - CFG_DELAY_UNIT: default clk cycles per delay count (1 ms at 100 MHz)
package camera_config_pkg;

   localparam int unsigned CFG_REG_W      = 8;
   localparam int unsigned CFG_VAL_W      = 8;
   localparam int unsigned CFG_ENTRY_W    = 2 + CFG_REG_W + CFG_VAL_W;
   localparam int unsigned CFG_DELAY_UNIT = 100000;

   typedef enum logic [1:0] {
      CFG_WRITE = 2'd0,
      CFG_DELAY = 2'd1,
      CFG_END   = 2'd2
   } cfg_op_t;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StLatch,
      StDecode,
      StReq,
      StWait,
      StDelay,
      StDone,
      StError
   } cfg_state_t;

   typedef struct packed {
      cfg_op_t                op;
      logic [CFG_REG_W-1:0]   reg_addr;
      logic [CFG_VAL_W-1:0]   val;
   } cfg_entry_t;

   function automatic logic [CFG_ENTRY_W-1:0] cfg_entry(cfg_op_t op,
                                                         logic [CFG_REG_W-1:0] reg_addr,
                                                         logic [CFG_VAL_W-1:0] val);
      cfg_entry_t e;
      e.op       = op;
      e.reg_addr = reg_addr;
      e.val      = val;
      return e;
   endfunction

endpackage

// File: rtl/camera_config_sequencer_if.sv
// SCCB write-request channel between the config sequencer and the SCCB master.
//   valid/reg_addr/val : request from the sequencer (held stable while valid)
//   ready              : master accepts the request
//   done/nack          : single-cycle completion pulse; nack qualified by done
// Modports: master (sequencer side), slave (SCCB master side).
interface camera_config_sequencer_if #(
   parameter int unsigned REG_W = 8,
   parameter int unsigned VAL_W = 8
);
   logic             valid;
   logic             ready;
   logic [REG_W-1:0] reg_addr;
   logic [VAL_W-1:0] val;
   logic             done;
   logic             nack;

   modport master (output valid, reg_addr, val, input ready, done, nack);
   modport slave  (input valid, reg_addr, val, output ready, done, nack);
endinterface

// File: rtl/camera_config_table.sv
// Synchronous configuration ROM holding the OV7670 init list with explicit
// DELAY entries. Entry format {op[1:0], reg[7:0], val[7:0]}.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (output reads as END)
//   addr_i : entry address
//   data_o : entry, valid one cycle after addr_i
// Addresses past the list return END.
module camera_config_table
   import camera_config_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [CFG_ENTRY_W-1:0] data_o
);

   logic [CFG_ENTRY_W-1:0] word;

   always_comb begin
      word = cfg_entry(CFG_END, 8'h00, 8'h00);
      case (addr_i)
         ADDR_W'(0):  word = cfg_entry(CFG_WRITE, 8'h12, 8'h80); // COM7 soft reset
         ADDR_W'(1):  word = cfg_entry(CFG_DELAY, 8'h00, 8'd10); // settle after reset
         ADDR_W'(2):  word = cfg_entry(CFG_WRITE, 8'h12, 8'h04); // COM7 RGB output
         ADDR_W'(3):  word = cfg_entry(CFG_WRITE, 8'h11, 8'h01); // CLKRC prescaler
         ADDR_W'(4):  word = cfg_entry(CFG_WRITE, 8'h0C, 8'h00); // COM3
         ADDR_W'(5):  word = cfg_entry(CFG_WRITE, 8'h3E, 8'h00); // COM14
         ADDR_W'(6):  word = cfg_entry(CFG_WRITE, 8'h40, 8'hD0); // COM15 RGB565
         ADDR_W'(7):  word = cfg_entry(CFG_WRITE, 8'h8C, 8'h00); // RGB444 off
         ADDR_W'(8):  word = cfg_entry(CFG_WRITE, 8'h3A, 8'h04); // TSLB
         ADDR_W'(9):  word = cfg_entry(CFG_WRITE, 8'h3D, 8'hC8); // COM13 gamma/UV
         ADDR_W'(10): word = cfg_entry(CFG_WRITE, 8'h13, 8'hE7); // COM8 AGC/AEC/AWB
         ADDR_W'(11): word = cfg_entry(CFG_DELAY, 8'h00, 8'd1);
         ADDR_W'(12): word = cfg_entry(CFG_END,   8'h00, 8'h00);
         default:     word = cfg_entry(CFG_END,   8'h00, 8'h00);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_o <= cfg_entry(CFG_END, 8'h00, 8'h00);
      end else begin
         data_o <= word;
      end
   end

endmodule

// File: rtl/camera_config_sequencer.sv
// Register-initialisation engine for SCCB-configured image sensors. Walks an
// external synchronous entry table {op, reg, val} and issues WRITEs to the SCCB
// master, with programmable DELAYs, NACK retry and an explicit END.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : pulse; (re)starts the walk at entry 0 when not busy
//   rom_addr_o/rom_data_i : table port, data one cycle after address
//   sccb                : write-request channel (master modport)
//   busy_o/done_o/error_o : walk status levels
//   fail_index_o        : failing entry, valid while error_o
// Optional: define CAMERA_CONFIG_STATS_EN to add write_count_o / nack_count_o.
module camera_config_sequencer
   import camera_config_pkg::*;
#(
   parameter int unsigned REG_W       = 8,
   parameter int unsigned VAL_W       = 8,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned DELAY_UNIT  = CFG_DELAY_UNIT,
   parameter int unsigned MAX_RETRIES = 3,
   localparam int unsigned ADDR_W  = $clog2(DEPTH),
   localparam int unsigned ENTRY_W = 2 + REG_W + VAL_W
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   output logic [ADDR_W-1:0]         rom_addr_o,
   input  logic [ENTRY_W-1:0]        rom_data_i,
   camera_config_sequencer_if.master sccb,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [ADDR_W-1:0]         fail_index_o
`ifdef CAMERA_CONFIG_STATS_EN
   ,
   output logic [15:0]               write_count_o,
   output logic [15:0]               nack_count_o
`endif
);

   // Delay counter must hold (2^VAL_W - 1) * DELAY_UNIT.
   localparam longint unsigned DlyMax = ((64'd1 << VAL_W) - 64'd1) * 64'(DELAY_UNIT);
   localparam int unsigned DlyW = $clog2(DlyMax + 64'd1);
   localparam int unsigned RtyW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

   cfg_state_t          state_q, state_d;
   logic [ADDR_W-1:0]   index_q, index_d;
   logic [ADDR_W-1:0]   fail_q, fail_d;
   logic [ENTRY_W-1:0]  entry_q, entry_d;
   logic [RtyW-1:0]     retry_q, retry_d;
   logic [DlyW-1:0]     delay_q, delay_d;
   logic                advance;
   logic                busy;
   logic [1:0]          op_bits;
   logic [VAL_W-1:0]    entry_val;

   assign op_bits   = entry_q[ENTRY_W-1 -: 2];
   assign entry_val = entry_q[VAL_W-1:0];
   assign busy      = !(state_q inside {StIdle, StDone, StError});

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      fail_d  = fail_q;
      entry_d = entry_q;
      retry_d = retry_q;
      delay_d = delay_q;
      advance = 1'b0;

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start_i) begin
               index_d = '0;
               retry_d = '0;
               delay_d = '0;
               fail_d  = '0;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            entry_d = rom_data_i;
            state_d = StDecode;
         end
         StDecode: begin
            case (op_bits)
               CFG_WRITE: state_d = StReq;
               CFG_DELAY: begin
                  if (entry_val == '0) begin
                     advance = 1'b1;
                  end else begin
                     delay_d = DlyW'(entry_val) * DlyW'(DELAY_UNIT);
                     state_d = StDelay;
                  end
               end
               // END and the reserved code both finish the walk.
               default: state_d = StDone;
            endcase
         end
         StReq: begin
            if (sccb.ready) state_d = StWait;
         end
         StWait: begin
            if (sccb.done) begin
               if (!sccb.nack) begin
                  advance = 1'b1;
               end else if (retry_q < RtyW'(MAX_RETRIES)) begin
                  retry_d = retry_q + RtyW'(1);
                  state_d = StReq;
               end else begin
                  fail_d  = index_q;
                  state_d = StError;
               end
            end
         end
         StDelay: begin
            // Loaded with val*DELAY_UNIT; leaves after exactly that many cycles.
            if (delay_q <= DlyW'(1)) begin
               delay_d = '0;
               advance = 1'b1;
            end else begin
               delay_d = delay_q - DlyW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         retry_d = '0;
         if (index_q == LastIdx) begin
            state_d = StDone;
         end else begin
            index_d = index_q + ADDR_W'(1);
            state_d = StFetch;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         index_q <= '0;
         fail_q  <= '0;
         entry_q <= '0;
         retry_q <= '0;
         delay_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         fail_q  <= fail_d;
         entry_q <= entry_d;
         retry_q <= retry_d;
         delay_q <= delay_d;
      end
   end

   assign rom_addr_o    = index_q;
   assign sccb.valid    = (state_q == StReq);
   assign sccb.reg_addr = entry_q[VAL_W +: REG_W];
   assign sccb.val      = entry_val;
   assign busy_o        = busy;
   assign done_o        = (state_q == StDone);
   assign error_o       = (state_q == StError);
   assign fail_index_o  = fail_q;

`ifdef CAMERA_CONFIG_STATS_EN
   logic [15:0] write_cnt_q, write_cnt_d;
   logic [15:0] nack_cnt_q, nack_cnt_d;

   always_comb begin
      write_cnt_d = write_cnt_q;
      nack_cnt_d  = nack_cnt_q;
      if (!busy && start_i) begin
         write_cnt_d = '0;
         nack_cnt_d  = '0;
      end else if (state_q == StWait && sccb.done) begin
         if (sccb.nack) begin
            if (nack_cnt_q != 16'hFFFF) nack_cnt_d = nack_cnt_q + 16'd1;
         end else begin
            if (write_cnt_q != 16'hFFFF) write_cnt_d = write_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         write_cnt_q <= '0;
         nack_cnt_q  <= '0;
      end else begin
         write_cnt_q <= write_cnt_d;
         nack_cnt_q  <= nack_cnt_d;
      end
   end

   assign write_count_o = write_cnt_q;
   assign nack_count_o  = nack_cnt_q;
`endif

endmodule

// File: tb/tb_camera_config_sequencer.sv
module tb_camera_config_sequencer;
   import camera_config_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start_a, start_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: 16 entries, short delay unit
   camera_config_sequencer_if #(.REG_W(8), .VAL_W(8)) sccb_a ();
   logic [3:0]  addr_a, fidx_a;
   logic [17:0] data_a;
   logic        busy_a, done_a, err_a;
   logic [17:0] mem_a [16];

   // DUT B: 4 entries, table without END
   camera_config_sequencer_if #(.REG_W(8), .VAL_W(8)) sccb_b ();
   logic [1:0]  addr_b, fidx_b;
   logic [17:0] data_b;
   logic        busy_b, done_b, err_b;
   logic [17:0] mem_b [4];

`ifdef CAMERA_CONFIG_STATS_EN
   logic [15:0] wc_a, nc_a, wc_b, nc_b;
`endif

   camera_config_sequencer #(
      .REG_W(8), .VAL_W(8), .DEPTH(16), .DELAY_UNIT(4), .MAX_RETRIES(3)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a),
      .rom_addr_o(addr_a), .rom_data_i(data_a), .sccb(sccb_a),
      .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .fail_index_o(fidx_a)
`ifdef CAMERA_CONFIG_STATS_EN
      , .write_count_o(wc_a), .nack_count_o(nc_a)
`endif
   );

   camera_config_sequencer #(
      .REG_W(8), .VAL_W(8), .DEPTH(4), .DELAY_UNIT(4), .MAX_RETRIES(3)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b),
      .rom_addr_o(addr_b), .rom_data_i(data_b), .sccb(sccb_b),
      .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .fail_index_o(fidx_b)
`ifdef CAMERA_CONFIG_STATS_EN
      , .write_count_o(wc_b), .nack_count_o(nc_b)
`endif
   );

   logic [6:0]  tbl_addr;
   logic [17:0] tbl_data;
   camera_config_table #(.DEPTH(128)) u_table (
      .clk_i(clk), .rst_i(rst), .addr_i(tbl_addr), .data_o(tbl_data)
   );

   // Synchronous table models
   always @(posedge clk) begin
      data_a <= mem_a[addr_a];
      data_b <= mem_b[addr_b];
   end

   // SCCB master model: ready 2 cycles after valid, done one cycle later,
   // NACKs taken from nack_plan in transaction order.
   bit          sel;
   logic        rsp_ready, rsp_done, rsp_nack;
   bit          nack_plan [32];
   int          nack_len, nack_ptr;
   logic [7:0]  log_reg [64];
   logic [7:0]  log_val [64];
   int          log_cyc [64];
   int          log_n;
   logic        s_valid;
   logic [7:0]  s_reg, s_val;

   assign sccb_a.ready = rsp_ready & ~sel;
   assign sccb_a.done  = rsp_done & ~sel;
   assign sccb_a.nack  = rsp_nack & ~sel;
   assign sccb_b.ready = rsp_ready & sel;
   assign sccb_b.done  = rsp_done & sel;
   assign sccb_b.nack  = rsp_nack & sel;
   assign s_valid = sel ? sccb_b.valid : sccb_a.valid;
   assign s_reg   = sel ? sccb_b.reg_addr : sccb_a.reg_addr;
   assign s_val   = sel ? sccb_b.val : sccb_a.val;

   initial begin
      int  cnt;
      bit  ph;
      cnt = 0;
      ph  = 1'b0;
      rsp_ready = 1'b0;
      rsp_done  = 1'b0;
      rsp_nack  = 1'b0;
      forever begin
         @(negedge clk);
         rsp_ready = 1'b0;
         rsp_done  = 1'b0;
         rsp_nack  = 1'b0;
         if (rst) begin
            cnt = 0;
            ph  = 1'b0;
         end else if (ph) begin
            rsp_done = 1'b1;
            rsp_nack = (nack_ptr < nack_len) ? nack_plan[nack_ptr] : 1'b0;
            nack_ptr = nack_ptr + 1;
            ph = 1'b0;
         end else if (s_valid) begin
            cnt = cnt + 1;
            if (cnt == 2) begin
               rsp_ready = 1'b1;
               if (log_n < 64) begin
                  log_reg[log_n] = s_reg;
                  log_val[log_n] = s_val;
                  log_cyc[log_n] = cyc;
               end
               log_n = log_n + 1;
               cnt = 0;
               ph  = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic clear_a();
      for (int i = 0; i < 16; i++) mem_a[i] = cfg_entry(CFG_END, 8'h00, 8'h00);
      log_n = 0;
      nack_len = 0;
      nack_ptr = 0;
      sel = 1'b0;
   endtask

   task automatic load_basic();
      clear_a();
      mem_a[0] = cfg_entry(CFG_WRITE, 8'h12, 8'h80);
      mem_a[1] = cfg_entry(CFG_DELAY, 8'h00, 8'd2);
      mem_a[2] = cfg_entry(CFG_WRITE, 8'h11, 8'h80);
   endtask

   task automatic pulse_start(input bit which);
      @(negedge clk);
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_end(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (sel ? (done_b | err_b) : (done_a | err_a)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, done_a, err_a, sccb_a.valid, addr_a, fidx_a} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %0h want 0",
                  {busy_a, done_a, err_a, sccb_a.valid, addr_a, fidx_a});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_b, done_b, err_b, sccb_b.valid, addr_b} !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle_b: got %0h want 0", {busy_b, done_b, err_b, sccb_b.valid, addr_b});
      end
   endtask

   task automatic test_table_rom();
      @(negedge clk);
      tbl_addr = 7'd0;
      @(negedge clk);
      checks++;
      if (tbl_data !== 18'h01280) begin
         errors++;
         $display("FAIL table_entry0: got %0h want 1280", tbl_data);
      end
      tbl_addr = 7'd1;
      @(negedge clk);
      checks++;
      if (tbl_data !== 18'h1000A) begin
         errors++;
         $display("FAIL table_delay: got %0h want 1000a", tbl_data);
      end
      tbl_addr = 7'd100;
      @(negedge clk);
      checks++;
      if (tbl_data !== 18'h20000) begin
         errors++;
         $display("FAIL table_out_of_range: got %0h want 20000", tbl_data);
      end
   endtask

   task automatic test_basic();
      bit ok;
      load_basic();
      pulse_start(1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sccb_a.valid !== 1'b0 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL basic_pre_valid: got valid=%0b busy=%0b want 0/1", sccb_a.valid, busy_a);
      end
      @(negedge clk);
      checks++;
      if ({sccb_a.valid, sccb_a.reg_addr, sccb_a.val} !== {1'b1, 8'h12, 8'h80}) begin
         errors++;
         $display("FAIL basic_first_valid: got %0h want 11280",
                  {sccb_a.valid, sccb_a.reg_addr, sccb_a.val});
      end
      wait_end(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout: got no end want done");
      end
      checks++;
      if (log_n != 2 || log_reg[0] !== 8'h12 || log_reg[1] !== 8'h11 || log_val[1] !== 8'h80) begin
         errors++;
         $display("FAIL basic_writes: got n=%0d %0h %0h want 2 12 11", log_n, log_reg[0], log_reg[1]);
      end
      checks++;
      if (log_cyc[1] - log_cyc[0] != 17) begin
         errors++;
         $display("FAIL basic_delay_gap: got %0d want 17", log_cyc[1] - log_cyc[0]);
      end
      checks++;
      if ({done_a, busy_a, err_a} !== 3'b100) begin
         errors++;
         $display("FAIL basic_status: got %0b want 100", {done_a, busy_a, err_a});
      end
   endtask

   task automatic test_nack_retry();
      bit ok;
      clear_a();
      mem_a[0] = cfg_entry(CFG_WRITE, 8'h0A, 8'h01);
      mem_a[1] = cfg_entry(CFG_WRITE, 8'h0B, 8'h02);
      mem_a[2] = cfg_entry(CFG_WRITE, 8'h0C, 8'h03);
      nack_plan[0] = 1'b0;
      nack_plan[1] = 1'b1;
      nack_plan[2] = 1'b1;
      nack_plan[3] = 1'b0;
      nack_len = 4;
      pulse_start(1'b0);
      wait_end(300, ok);
      checks++;
      if (!ok || log_n != 5) begin
         errors++;
         $display("FAIL retry_count: got ok=%0b n=%0d want 1 5", ok, log_n);
      end
      checks++;
      if ({log_reg[1], log_reg[2], log_reg[3], log_reg[4]} !== 32'h0B0B0B0C) begin
         errors++;
         $display("FAIL retry_order: got %0h want 0b0b0b0c",
                  {log_reg[1], log_reg[2], log_reg[3], log_reg[4]});
      end
      checks++;
      if ({done_a, err_a} !== 2'b10) begin
         errors++;
         $display("FAIL retry_status: got %0b want 10", {done_a, err_a});
      end
   endtask

   task automatic test_nack_error();
      bit ok;
      clear_a();
      for (int i = 0; i < 7; i++) mem_a[i] = cfg_entry(CFG_WRITE, 8'h50 + 8'(i), 8'(i));
      for (int i = 0; i < 9; i++) nack_plan[i] = (i >= 5);
      nack_len = 9;
      pulse_start(1'b0);
      wait_end(400, ok);
      checks++;
      if (!ok || log_n != 9 || log_reg[8] !== 8'h55) begin
         errors++;
         $display("FAIL error_attempts: got ok=%0b n=%0d last=%0h want 1 9 55", ok, log_n, log_reg[8]);
      end
      checks++;
      if ({err_a, done_a, busy_a, fidx_a} !== {3'b100, 4'd5}) begin
         errors++;
         $display("FAIL error_status: got %0h want 45", {err_a, done_a, busy_a, fidx_a});
      end
      repeat (20) @(negedge clk);
      checks++;
      if (log_n != 9 || sccb_a.valid !== 1'b0) begin
         errors++;
         $display("FAIL error_quiet: got n=%0d valid=%0b want 9 0", log_n, sccb_a.valid);
      end
      nack_len = 0;
      log_n = 0;
      pulse_start(1'b0);
      checks++;
      if ({busy_a, err_a, addr_a} !== {2'b10, 4'd0}) begin
         errors++;
         $display("FAIL error_restart: got %0h want 20", {busy_a, err_a, addr_a});
      end
      wait_end(400, ok);
      checks++;
      if (!ok || done_a !== 1'b1 || log_n != 7 || log_reg[0] !== 8'h50) begin
         errors++;
         $display("FAIL error_rewalk: got ok=%0b done=%0b n=%0d first=%0h want 1 1 7 50",
                  ok, done_a, log_n, log_reg[0]);
      end
   endtask

   task automatic test_depth_limit();
      bit ok;
      sel = 1'b1;
      log_n = 0;
      nack_len = 0;
      nack_ptr = 0;
      for (int i = 0; i < 4; i++) mem_b[i] = cfg_entry(CFG_WRITE, 8'h21 + 8'(i), 8'(i + 1));
      pulse_start(1'b1);
      wait_end(200, ok);
      checks++;
      if (!ok || {done_b, busy_b, err_b} !== 3'b100) begin
         errors++;
         $display("FAIL depth_status: got ok=%0b %0b want 1 100", ok, {done_b, busy_b, err_b});
      end
      repeat (20) @(negedge clk);
      checks++;
      if (log_n != 4 || log_reg[3] !== 8'h24 || addr_b !== 2'd3) begin
         errors++;
         $display("FAIL depth_writes: got n=%0d last=%0h addr=%0d want 4 24 3",
                  log_n, log_reg[3], addr_b);
      end
      sel = 1'b0;
   endtask

   task automatic test_start_ignored();
      bit ok;
      load_basic();
      pulse_start(1'b0);
      repeat (10) @(negedge clk);
      pulse_start(1'b0);
      checks++;
      if ({busy_a, addr_a} !== {1'b1, 4'd1}) begin
         errors++;
         $display("FAIL restart_ignored: got %0h want 11", {busy_a, addr_a});
      end
      wait_end(200, ok);
      checks++;
      if (!ok || log_n != 2 || log_cyc[1] - log_cyc[0] != 17) begin
         errors++;
         $display("FAIL restart_walk: got ok=%0b n=%0d gap=%0d want 1 2 17",
                  ok, log_n, log_cyc[1] - log_cyc[0]);
      end
   endtask

   task automatic test_delay_zero();
      bit ok;
      clear_a();
      mem_a[0] = cfg_entry(CFG_WRITE, 8'h01, 8'h11);
      mem_a[1] = cfg_entry(CFG_DELAY, 8'h00, 8'd0);
      mem_a[2] = cfg_entry(CFG_WRITE, 8'h02, 8'h22);
      pulse_start(1'b0);
      wait_end(200, ok);
      checks++;
      if (!ok || log_n != 2 || log_val[1] !== 8'h22) begin
         errors++;
         $display("FAIL delay0_writes: got ok=%0b n=%0d want 1 2", ok, log_n);
      end
      checks++;
      if (log_cyc[1] - log_cyc[0] != 9) begin
         errors++;
         $display("FAIL delay0_gap: got %0d want 9", log_cyc[1] - log_cyc[0]);
      end
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      load_basic();
      pulse_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (log_n == 1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #2;
      checks++;
      if (!ok || busy_a !== 1'b1 || sccb_a.valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_setup: got ok=%0b busy=%0b valid=%0b want 1 1 0",
                  ok, busy_a, sccb_a.valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, done_a, err_a, sccb_a.valid, sccb_a.reg_addr, sccb_a.val, addr_a, fidx_a}
          !== 28'd0) begin
         errors++;
         $display("FAIL rst_wait_outputs: got %0h want 0",
                  {busy_a, done_a, err_a, sccb_a.valid, sccb_a.reg_addr, sccb_a.val, addr_a, fidx_a});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({busy_a, done_a, sccb_a.valid} !== 3'b000 || log_n != 1) begin
         errors++;
         $display("FAIL rst_wait_idle: got %0b n=%0d want 000 1", {busy_a, done_a, sccb_a.valid}, log_n);
      end
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      tbl_addr = '0;
      sel = 1'b0;
      log_n = 0;
      nack_len = 0;
      nack_ptr = 0;
      for (int i = 0; i < 16; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++) mem_b[i] = '0;
      test_reset();
      test_table_rom();
      test_basic();
      test_nack_retry();
      test_nack_error();
      test_depth_limit();
      test_start_ignored();
      test_delay_zero();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
